// File: rtl/reaction_round_scheduler.sv
// Reaction-time game sequencer.
// Runs ROUNDS rounds: arm a random countdown, wait for it to expire, light a
// target LED and time the player's button press with an external ms timer.
// Pressing during the countdown is a false start and scores MAX_MS.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, button_pressed level inputs; their rising edges are the events
//   random_delay          countdown preload, sampled in ARM
//   random_led            target LED index, latched in ARM
//   timer_value           current external timer count
//   timer_*               external timer controls (decoded from state)
//   led_on                one-hot target LED, lit only while reacting
//   round_idx             completed-round count
//   last_ms/best_ms/avg_ms latest, minimum and mean reaction time
//   false_start           sticky: at least one false start this game
//   busy, done            game in progress / results valid
module reaction_round_scheduler #(
  parameter  int MAX_MS  = 2047,
  parameter  int LED_NUM = 17,
  parameter  int ROUNDS  = 4,
  localparam int TW      = $clog2(MAX_MS),
  localparam int LW      = (LED_NUM > 1) ? $clog2(LED_NUM) : 1,
  localparam int LOG_R   = $clog2(ROUNDS),
  localparam int RW      = LOG_R + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               button_pressed,
  input  logic [TW-1:0]      random_delay,
  input  logic [LW-1:0]      random_led,
  input  logic [TW-1:0]      timer_value,
  output logic               timer_clear,
  output logic               timer_load,
  output logic [TW-1:0]      timer_load_value,
  output logic               timer_up,
  output logic               timer_enable,
  output logic [LED_NUM-1:0] led_on,
  output logic [RW-1:0]      round_idx,
  output logic [TW-1:0]      last_ms,
  output logic [TW-1:0]      best_ms,
  output logic [TW-1:0]      avg_ms,
  output logic               false_start,
  output logic               busy,
  output logic               done
);

  // Sum of ROUNDS values each <= MAX_MS fits in TW+LOG_R bits.
  localparam int            SW       = TW + LOG_R;
  localparam logic [TW-1:0] MAX_L    = TW'(MAX_MS);
  localparam logic [RW-1:0] ROUNDS_L = RW'(ROUNDS);

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_WAIT, S_GO, S_REACT, S_CAPTURE, S_PENALTY, S_NEXT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          start_q, btn_q;
  logic [RW-1:0] round_q, round_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [TW-1:0] last_q, last_d;
  logic [TW-1:0] best_q, best_d;
  logic [TW-1:0] avg_q, avg_d;
  logic          fs_q, fs_d;
  logic [LW-1:0] led_idx_q, led_idx_d;
  logic          start_edge, btn_edge;

  assign start_edge = start & ~start_q;
  assign btn_edge   = button_pressed & ~btn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      btn_q     <= 1'b0;
      round_q   <= '0;
      sum_q     <= '0;
      last_q    <= '0;
      best_q    <= MAX_L;
      avg_q     <= '0;
      fs_q      <= 1'b0;
      led_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      btn_q     <= button_pressed;
      round_q   <= round_d;
      sum_q     <= sum_d;
      last_q    <= last_d;
      best_q    <= best_d;
      avg_q     <= avg_d;
      fs_q      <= fs_d;
      led_idx_q <= led_idx_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    round_d          = round_q;
    sum_d            = sum_q;
    last_d           = last_q;
    best_d           = best_q;
    avg_d            = avg_q;
    fs_d             = fs_q;
    led_idx_d        = led_idx_q;
    timer_clear      = 1'b0;
    timer_load       = 1'b0;
    timer_load_value = '0;
    timer_up         = 1'b0;
    timer_enable     = 1'b0;
    led_on           = '0;
    done             = 1'b0;
    busy             = (state_q != S_IDLE) && (state_q != S_DONE);

    unique case (state_q)
      // IDLE and DONE share the new-game path; only their static outputs differ.
      S_IDLE, S_DONE: begin
        if (state_q == S_IDLE) timer_clear = 1'b1;
        else                   done        = 1'b1;
        if (start_edge) begin
          round_d = '0;
          sum_d   = '0;
          last_d  = '0;
          fs_d    = 1'b0;
          best_d  = MAX_L;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        timer_load       = 1'b1;
        timer_load_value = random_delay;
        led_idx_d        = random_led;
        state_d          = S_WAIT;
      end
      S_WAIT: begin
        timer_enable = 1'b1;
        // A press on the same cycle the countdown expires is still early.
        if (btn_edge)                state_d = S_PENALTY;
        else if (timer_value == '0)  state_d = S_GO;
      end
      S_GO: begin
        timer_clear = 1'b1;
        state_d     = S_REACT;
      end
      S_REACT: begin
        timer_enable = 1'b1;
        timer_up     = 1'b1;
        led_on       = LED_NUM'(1) << led_idx_q;
        if (btn_edge || (timer_value == MAX_L)) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        last_d = timer_value;
        sum_d  = sum_q + SW'(timer_value);
        if (timer_value < best_q) best_d = timer_value;
        state_d = S_NEXT;
      end
      S_PENALTY: begin
        fs_d    = 1'b1;
        last_d  = MAX_L;
        sum_d   = sum_q + SW'(MAX_L);
        state_d = S_NEXT;
      end
      S_NEXT: begin
        round_d = round_q + RW'(1);
        if (round_d == ROUNDS_L) begin
          avg_d   = sum_q[SW-1:LOG_R];
          state_d = S_DONE;
        end else begin
          state_d = S_ARM;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign round_idx   = round_q;
  assign last_ms     = last_q;
  assign best_ms     = best_q;
  assign avg_ms      = avg_q;
  assign false_start = fs_q;

endmodule

// File: tb/tb_reaction_round_scheduler.sv
// Directed bench for reaction_round_scheduler with a saturating ms timer
// that ticks once per clock.
module tb_reaction_round_scheduler;
  localparam int TW = 11;
  localparam int LW = 5;
  localparam int MAXV = 2047;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          button_pressed = 1'b0;
  logic [TW-1:0] random_delay = '0;
  logic [LW-1:0] random_led = '0;
  logic [TW-1:0] timer_value = '0;
  logic          timer_clear, timer_load, timer_up, timer_enable;
  logic [TW-1:0] timer_load_value;
  logic [16:0]   led_on;
  logic [2:0]    round_idx;
  logic [TW-1:0] last_ms, best_ms, avg_ms;
  logic          false_start, busy, done;

  int vectors = 0;
  int miscompares = 0;

  reaction_round_scheduler #(.MAX_MS(2047), .LED_NUM(17), .ROUNDS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .button_pressed(button_pressed),
    .random_delay(random_delay), .random_led(random_led),
    .timer_value(timer_value), .timer_clear(timer_clear),
    .timer_load(timer_load), .timer_load_value(timer_load_value),
    .timer_up(timer_up), .timer_enable(timer_enable), .led_on(led_on),
    .round_idx(round_idx), .last_ms(last_ms), .best_ms(best_ms),
    .avg_ms(avg_ms), .false_start(false_start), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // External timer: clear > load > count; saturates at 0 and MAXV.
  always @(posedge clk) begin
    if (timer_clear)       timer_value <= '0;
    else if (timer_load)   timer_value <= timer_load_value;
    else if (timer_enable) begin
      if (timer_up) timer_value <= (timer_value == TW'(MAXV)) ? timer_value : timer_value + 1'b1;
      else          timer_value <= (timer_value == '0) ? timer_value : timer_value - 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance until the REACT state (timer enabled, counting up) is visible.
  task automatic to_react();
    int n = 0;
    while (!(timer_enable && timer_up) && n < 200) begin tick(); n++; end
    chk("reach_react", 32'(n < 200), 1);
  endtask

  // Press so that the timer has ticked val times since GO when CAPTURE samples it.
  // Returns with the FSM in NEXT.
  task automatic react_press(input int val, input int led);
    int n = 0;
    while (!(timer_enable && timer_up && timer_value == TW'(val - 1)) && n < 3000) begin
      tick(); n++;
    end
    chk("reach_press_point", 32'(n < 3000), 1);
    chk("led_onehot", 32'(led_on), 32'(1) << led);
    button_pressed = 1'b1;
    tick();
    button_pressed = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_best", 32'(best_ms), MAXV);
    chk("rst_round", 32'(round_idx), 0);
    chk("rst_last", 32'(last_ms), 0);
    chk("rst_avg", 32'(avg_ms), 0);
    chk("rst_fs", 32'(false_start), 0);
    chk("rst_led", 32'(led_on), 0);
    chk("rst_tclear", 32'(timer_clear), 1);
    rst = 1'b0;
    tick();

    // Game 1: normal game, presses 30/40/20/50
    random_delay = 11'd5;
    random_led = 5'd3;
    start = 1'b1;
    tick();
    chk("g1_arm_load", 32'(timer_load), 1);
    chk("g1_arm_value", 32'(timer_load_value), 5);
    chk("g1_busy", 32'(busy), 1);
    start = 1'b0;
    tick();
    chk("g1_wait_en", 32'(timer_enable), 1);
    chk("g1_wait_up", 32'(timer_up), 0);
    chk("g1_wait_led", 32'(led_on), 0);
    react_press(30, 3);
    chk("g1_r1_last", 32'(last_ms), 30);
    random_led = 5'd16;
    tick();
    chk("g1_r1_round", 32'(round_idx), 1);
    react_press(40, 16);
    chk("g1_r2_last", 32'(last_ms), 40);
    chk("g1_r2_best", 32'(best_ms), 30);
    random_led = 5'd0;
    tick();
    react_press(20, 0);
    chk("g1_r3_best", 32'(best_ms), 20);
    random_led = 5'd7;
    tick();
    react_press(50, 7);
    tick();
    chk("g1_done", 32'(done), 1);
    chk("g1_busy_end", 32'(busy), 0);
    chk("g1_round", 32'(round_idx), 4);
    chk("g1_best", 32'(best_ms), 20);
    chk("g1_avg", 32'(avg_ms), 35);
    chk("g1_fs", 32'(false_start), 0);
    chk("g1_last", 32'(last_ms), 50);
    tick();
    chk("g1_done_hold", 32'(done), 1);

    // Game 2: start from DONE, false start in round 2, ignored start in REACT
    random_led = 5'd2;
    start = 1'b1;
    tick();
    chk("g2_arm_load", 32'(timer_load), 1);
    chk("g2_round_clr", 32'(round_idx), 0);
    chk("g2_last_clr", 32'(last_ms), 0);
    chk("g2_best_clr", 32'(best_ms), MAXV);
    chk("g2_done_clr", 32'(done), 0);
    start = 1'b0;
    react_press(30, 2);
    chk("g2_r1_last", 32'(last_ms), 30);
    tick();
    tick();
    chk("g2_r2_wait", 32'(timer_enable && !timer_up), 1);
    button_pressed = 1'b1;
    tick();
    chk("g2_pen_no_go", 32'(timer_clear), 0);
    button_pressed = 1'b0;
    tick();
    chk("g2_pen_fs", 32'(false_start), 1);
    chk("g2_pen_last", 32'(last_ms), MAXV);
    chk("g2_pen_best", 32'(best_ms), 30);
    tick();
    chk("g2_r2_round", 32'(round_idx), 2);
    to_react();
    start = 1'b1;
    tick();
    chk("g2_start_ign_react", 32'(timer_enable && timer_up), 1);
    chk("g2_start_ign_round", 32'(round_idx), 2);
    start = 1'b0;
    react_press(40, 2);
    tick();
    react_press(20, 2);
    tick();
    chk("g2_done", 32'(done), 1);
    chk("g2_round", 32'(round_idx), 4);
    chk("g2_best", 32'(best_ms), 20);
    chk("g2_avg", 32'(avg_ms), 534);
    chk("g2_fs", 32'(false_start), 1);

    // Game 3: collision at timer 0, then timeout, then reset mid-REACT
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    begin
      int n = 0;
      while (!(timer_enable && !timer_up && timer_value == '0) && n < 50) begin tick(); n++; end
      chk("g3_reach_zero", 32'(n < 50), 1);
    end
    button_pressed = 1'b1;
    tick();
    chk("g3_coll_no_go", 32'(timer_clear), 0);
    chk("g3_coll_busy", 32'(busy), 1);
    button_pressed = 1'b0;
    tick();
    chk("g3_coll_fs", 32'(false_start), 1);
    chk("g3_coll_last", 32'(last_ms), MAXV);
    tick();
    to_react();
    begin
      int n = 0;
      while ((timer_enable && timer_up) && n < 2200) begin tick(); n++; end
      chk("g3_timeout_exit", 32'(n < 2200), 1);
    end
    tick();
    chk("g3_timeout_last", 32'(last_ms), MAXV);
    chk("g3_timeout_best", 32'(best_ms), MAXV);
    tick();
    to_react();
    tick();
    chk("g3_react_led", 32'(led_on), 32'(1) << 2);
    button_pressed = 1'b1;
    rst = 1'b1;
    #1;
    chk("rstm_led", 32'(led_on), 0);
    chk("rstm_busy", 32'(busy), 0);
    chk("rstm_best", 32'(best_ms), MAXV);
    chk("rstm_round", 32'(round_idx), 0);
    chk("rstm_idle", 32'(timer_clear), 1);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    tick();
    chk("g4_arm_load", 32'(timer_load), 1);
    start = 1'b0;
    to_react();
    chk("g4_held_btn_no_fs", 32'(false_start), 0);
    chk("g4_held_btn_round", 32'(round_idx), 0);
    button_pressed = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/reaction_round_scheduler.md
REACTION_ROUND_SCHEDULER -- requirements
Module: reaction_round_scheduler

Interface
REQ-001 Parameter MAX_MS, default 2047, meaning full-scale millisecond timer value; TW = $clog2(MAX_MS).
REQ-002 Parameter LED_NUM, default 17, meaning number of target LEDs.
REQ-003 Parameter ROUNDS, default 4, meaning rounds per game; SHALL be a power of two, at least 2.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  level input; rising edge begins a game.
REQ-007 button_pressed  in  1  player button level; rising edge is the event.
REQ-008 random_delay  in  TW  countdown preload for the current round; sampled in ARM.
REQ-009 random_led  in  $clog2(LED_NUM)  target LED index; sampled in ARM.
REQ-010 timer_value  in  TW  current count of the external ms timer.
REQ-011 timer_clear  out  1  synchronous clear of the external timer to 0.
REQ-012 timer_load  out  1  loads timer_load_value into the timer.
REQ-013 timer_load_value  out  TW  preload value.
REQ-014 timer_up  out  1  count direction; 1 = up, 0 = down.
REQ-015 timer_enable  out  1  timer counts on its ms tick while high.
REQ-016 led_on  out  LED_NUM  one-hot target LED.
REQ-017 round_idx  out  $clog2(ROUNDS)+1  completed-round count.
REQ-018 last_ms, best_ms, avg_ms  out  TW each  latest, minimum and mean reaction time.
REQ-019 false_start  out  1  sticky flag: at least one false start this game.
REQ-020 busy / done  out  1 each  game in progress / results valid.

Function
REQ-021 Rising edges of start and button_pressed SHALL be detected with one register stage; an edge is a single-cycle event.
REQ-022 States SHALL be IDLE, ARM, WAIT, GO, REACT, CAPTURE, PENALTY, NEXT, DONE.
REQ-023 IDLE: timer_clear=1. On a start edge, SHALL clear round_idx, sum, last_ms and false_start, set best_ms=MAX_MS, and go to ARM.
REQ-024 ARM (1 cycle): timer_load=1, timer_load_value=random_delay; random_led SHALL be latched; next state WAIT.
REQ-025 WAIT: timer_enable=1, timer_up=0, led_on=0. A button edge SHALL go to PENALTY; otherwise timer_value==0 SHALL go to GO.
REQ-026 WAIT, button edge and timer_value==0 in the same cycle: PENALTY SHALL win.
REQ-027 GO (1 cycle): timer_clear=1; next state REACT.
REQ-028 REACT: timer_enable=1, timer_up=1, led_on=1<<latched index. A button edge or timer_value==MAX_MS (timeout) SHALL go to CAPTURE.
REQ-029 CAPTURE (1 cycle): last_ms<=timer_value; sum+=timer_value; best_ms<=timer_value if strictly less than best_ms.
REQ-030 PENALTY (1 cycle): false_start<=1; last_ms<=MAX_MS; sum+=MAX_MS; best_ms unchanged.
REQ-031 NEXT (1 cycle): round_idx+=1. If the new value equals ROUNDS, SHALL go to DONE and set avg_ms<=sum>>log2(ROUNDS); otherwise go to ARM.
REQ-032 sum SHALL be TW+$clog2(ROUNDS) bits wide and SHALL never overflow.
REQ-033 DONE: done=1, timer_enable=0; all results held. A start edge SHALL begin a new game exactly as from IDLE.
REQ-034 Start edges outside IDLE and DONE SHALL be ignored. Button edges in IDLE, ARM, GO, CAPTURE, PENALTY, NEXT and DONE SHALL be ignored.
REQ-035 busy SHALL be 1 in every state except IDLE and DONE.
REQ-036 Every output not named for a state SHALL be 0 in that state; timer controls and led_on SHALL be decoded combinationally from state.

Reset
REQ-037 rst high SHALL immediately force IDLE, whatever the current state.
REQ-038 rst high SHALL immediately set round_idx, last_ms, avg_ms, sum, false_start, done, busy and led_on to 0, best_ms to MAX_MS, and both edge registers to 0.

Verification
REQ-039 Normal game: ROUNDS=4, delays 5, press 30/40/20/50 ticks after GO -> best_ms=20, avg_ms=35, false_start=0, done=1.
REQ-040 False start: press during WAIT of round 2 -> PENALTY, false_start=1, last_ms=MAX_MS; best_ms excludes it; game still completes 4 rounds.
REQ-041 Same-cycle collision: button edge when timer_value==0 in WAIT -> PENALTY, never GO.
REQ-042 Timeout: no press in REACT -> CAPTURE at timer_value=2047, last_ms=2047.
REQ-043 rst asserted mid-REACT -> IDLE immediately, led_on=0, busy=0, best_ms=2047; a held button gives no edge after release of rst.
REQ-044 Start edge in REACT is ignored; start edge in DONE -> results cleared, ARM next cycle.
